// File: rtl/fplan_hier_pkg.sv
// Shared definitions for the fplan hierarchy pipeline.
// - Default parameter values for the chain and its stages.
// - ptr_w(): FIFO pointer width, never narrower than one bit.
// - tag(): value stage i adds to each word it stores.
package fplan_hier_pkg;

    localparam int NUM_STAGE_DEF = 4;
    localparam int DATA_W_DEF    = 30;
    localparam int DEPTH_DEF     = 2;
    localparam int TAG_EN_DEF    = 1;
    localparam int CNT_W_DEF     = 16;

    // A single-entry FIFO still needs a one-bit pointer register.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

    function automatic int tag(input int i);
        return i + 1;
    endfunction

endpackage

// File: rtl/fplan_pipe_stage.sv
// One pipeline stage: a registered FIFO with a constant adder on the write side.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   up_valid/up_ready   upstream handshake; up_ready = !full
//   up_data             upstream payload; stored as up_data + TAG (wraps)
//   dn_valid/dn_ready   downstream handshake; dn_valid = !empty
//   dn_data             head entry, zero while empty
//   occ                 stage holds at least one word
module fplan_pipe_stage
    import fplan_hier_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TAG    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic              occ
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready depends on our own fill level only, so a full stage waits one
    // cycle after a pop before accepting again.
    assign up_ready = !full;
    assign dn_valid = !empty;
    assign occ      = !empty;
    assign dn_data  = empty ? '0 : mem[rd_ptr];

    assign push = up_valid & up_ready;
    assign pop  = dn_valid & dn_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= up_data + DATA_W'(TAG);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fplan_hier_pipe.sv
// Chain of NUM_STAGE FIFO stages linked by valid/ready buses, kept as
// separate sibling instances.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    chain input handshake (in_ready low during reset)
//   in_data              input payload
//   out_valid/out_ready  chain output handshake (out_valid low during reset)
//   out_data             head of last stage, zero during reset or when empty
//   xfer_cnt             completed output transfers, wrapping
//   occ_any              any stage non-empty (from registered state only)
module fplan_hier_pipe
    import fplan_hier_pkg::*;
#(
    parameter int NUM_STAGE = NUM_STAGE_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int TAG_EN    = TAG_EN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              occ_any
);

    // Bus index i is the input of stage i; index NUM_STAGE is the chain output.
    logic [NUM_STAGE:0]   bus_valid;
    logic [NUM_STAGE:0]   bus_ready;
    logic [DATA_W-1:0]    bus_data [NUM_STAGE+1];
    logic [NUM_STAGE-1:0] stage_occ;

    assign bus_valid[0]         = in_valid;
    assign bus_data[0]          = in_data;
    assign bus_ready[NUM_STAGE] = out_ready;

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        fplan_pipe_stage #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .TAG    ((TAG_EN != 0) ? tag(i) : 0)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .up_valid (bus_valid[i]),
            .up_ready (bus_ready[i]),
            .up_data  (bus_data[i]),
            .dn_valid (bus_valid[i+1]),
            .dn_ready (bus_ready[i+1]),
            .dn_data  (bus_data[i+1]),
            .occ      (stage_occ[i])
        );
    end

    // Handshake outputs are forced idle while reset is held so nothing is
    // offered or accepted in the cycle reset is first applied.
    assign in_ready  = bus_ready[0] & ~reset;
    assign out_valid = bus_valid[NUM_STAGE] & ~reset;
    assign out_data  = reset ? '0 : bus_data[NUM_STAGE];
    assign occ_any   = |stage_occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fplan_hier_pipe.sv
module tb_fplan_hier_pipe;

    localparam int DW = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Default configuration: 4 stages, depth 2, tagging on.
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_occ;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [15:0]   a_cnt;

    // Narrow transfer counter.
    logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_occ;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [3:0]    c_cnt;

    // Corner: one stage, depth 1, no tagging.
    logic          k_in_valid, k_in_ready, k_out_valid, k_out_ready, k_occ;
    logic [DW-1:0] k_in_data, k_out_data;
    logic [15:0]   k_cnt;

    fplan_hier_pipe #(.NUM_STAGE(4), .DATA_W(DW), .DEPTH(2), .TAG_EN(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .xfer_cnt(a_cnt), .occ_any(a_occ));

    fplan_hier_pipe #(.NUM_STAGE(4), .DATA_W(DW), .DEPTH(2), .TAG_EN(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .xfer_cnt(c_cnt), .occ_any(c_occ));

    fplan_hier_pipe #(.NUM_STAGE(1), .DATA_W(DW), .DEPTH(1), .TAG_EN(0), .CNT_W(16)) dut_k (
        .clk(clk), .reset(reset),
        .in_valid(k_in_valid), .in_ready(k_in_ready), .in_data(k_in_data),
        .out_valid(k_out_valid), .out_ready(k_out_ready), .out_data(k_out_data),
        .xfer_cnt(k_cnt), .occ_any(k_occ));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a word crossing n tagging stages gains 1+2+...+n, modulo 2^DW.
    function automatic logic [DW-1:0] expect_out(input logic [DW-1:0] x, input int stages, input bit en);
        longint s;
        s = longint'(x) + (en ? longint'(stages * (stages + 1) / 2) : 64'sd0);
        return s[DW-1:0];
    endfunction

    task automatic idle_inputs();
        a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
        c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
        k_in_valid = 0; k_in_data = '0; k_out_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        n_tests++; if (a_occ !== 1'b0) begin n_fail++; $display("FAIL reset_occ_any got=%b exp=0", a_occ); end
        n_tests++; if (a_out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", a_out_data); end
        n_tests++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_xfer_cnt got=%0d exp=0", a_cnt); end
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got=%b exp=0", a_out_valid); end
    endtask

    task automatic test_single();
        int lat;
        logic [DW-1:0] seen;
        lat = -1;
        seen = '0;
        do_reset();
        a_out_ready = 1;
        a_in_valid = 1;
        a_in_data = 30'h100;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept in_ready=%b exp=1", a_in_ready); end
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            a_in_valid = 0;
            #1;
            if (a_out_valid === 1'b1) begin lat = k; seen = a_out_data; end
        end
        n_tests++; if (lat != 4) begin n_fail++; $display("FAIL single_latency got=%0d exp=4", lat); end
        n_tests++; if (seen !== 30'h10A) begin n_fail++; $display("FAIL single_data got=%h exp=10a", seen); end
        @(negedge clk);
        #1;
        n_tests++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL single_xfer_cnt got=%0d exp=1", a_cnt); end
        n_tests++; if (a_occ !== 1'b0) begin n_fail++; $display("FAIL single_drained occ_any=%b exp=0", a_occ); end
    endtask

    task automatic test_stream();
        int sent, got, first, last, stalls;
        sent = 0; got = 0; first = -1; last = -1; stalls = 0;
        do_reset();
        a_out_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            a_in_valid = (sent < 16);
            a_in_data  = DW'(sent);
            #1;
            if (a_in_valid && a_in_ready) sent++;
            else if (a_in_valid) stalls++;
            if (a_out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                last = cyc;
                n_tests++;
                if (a_out_data !== expect_out(DW'(got), 4, 1)) begin
                    n_fail++; $display("FAIL stream_data idx=%0d got=%h exp=%h", got, a_out_data, expect_out(DW'(got), 4, 1));
                end
                got++;
            end
        end
        a_in_valid = 0;
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL stream_in_stalls got=%0d exp=0", stalls); end
        n_tests++; if (got != 16 || last - first != 15) begin n_fail++; $display("FAIL stream_consecutive words=%0d span=%0d exp 16/15", got, last - first); end
        n_tests++; if (a_cnt !== 16'd16) begin n_fail++; $display("FAIL stream_xfer_cnt got=%0d exp=16", a_cnt); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] q[$];
        logic [DW-1:0] w;
        int acc, got;
        acc = 0; got = 0;
        do_reset();
        a_out_ready = 0;
        w = DW'($urandom);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            a_in_valid = 1;
            a_in_data  = w;
            #1;
            if (a_in_ready) begin
                q.push_back(expect_out(w, 4, 1));
                acc++;
                w = DW'($urandom);
            end
        end
        n_tests++; if (acc != 8) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=8", acc); end
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got=%b exp=0", a_in_ready); end
        @(negedge clk);
        a_in_valid = 0;
        a_out_ready = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            #1;
            if (a_out_valid === 1'b1) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra_word got=%h exp=none", a_out_data);
                end else begin
                    w = q.pop_front();
                    if (a_out_data !== w) begin n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, a_out_data, w); end
                end
                got++;
            end
            @(negedge clk);
        end
        n_tests++; if (got != 8) begin n_fail++; $display("FAIL bp_released got=%0d exp=8", got); end
        n_tests++; if (a_occ !== 1'b0) begin n_fail++; $display("FAIL bp_drained occ_any=%b exp=0", a_occ); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] seen;
        bit found;
        int sent, outs;
        found = 0; seen = '0;
        do_reset();
        a_out_ready = 1;
        a_in_valid = 1;
        a_in_data = 30'h3FFFFFFF;
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            a_in_valid = 0;
            #1;
            if (a_out_valid === 1'b1) begin found = 1; seen = a_out_data; end
        end
        n_tests++; if (!found || seen !== 30'h9) begin n_fail++; $display("FAIL data_wrap found=%0d got=%h exp=9", found, seen); end

        sent = 0; outs = 0;
        c_out_ready = 1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            c_in_valid = (sent < 17);
            c_in_data  = DW'($urandom);
            #1;
            if (c_in_valid && c_in_ready) sent++;
            if (c_out_valid === 1'b1) outs++;
        end
        c_in_valid = 0;
        n_tests++; if (outs != 17) begin n_fail++; $display("FAIL cnt_wrap_transfers got=%0d exp=17", outs); end
        n_tests++; if (c_cnt !== 4'(outs)) begin n_fail++; $display("FAIL cnt_wrap got=%0d exp=%0d", c_cnt, outs % 16); end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] w;
        int lat, early;
        lat = -1; early = 0;
        do_reset();
        a_out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_in_valid = 1;
            a_in_data  = DW'($urandom);
        end
        @(negedge clk);
        a_in_valid = 0;
        @(negedge clk);
        #1;
        // Words 1 and 2 have left (each takes 4 cycles), words 3..5 are inside.
        n_tests++; if (a_cnt !== 16'd2 || a_occ !== 1'b1) begin n_fail++; $display("FAIL mid_pre cnt=%0d occ=%b exp 2/1", a_cnt, a_occ); end
        reset = 1;
        @(negedge clk);
        #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b exp=0", a_out_valid); end
        n_tests++; if (a_occ !== 1'b0) begin n_fail++; $display("FAIL mid_occ_any got=%b exp=0", a_occ); end
        n_tests++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_xfer_cnt got=%0d exp=0", a_cnt); end
        reset = 0;
        @(negedge clk);
        #1;
        if (a_out_valid === 1'b1) early++;
        @(negedge clk);
        w = DW'($urandom);
        a_in_valid = 1;
        a_in_data  = w;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            a_in_valid = 0;
            #1;
            if (a_out_valid === 1'b1) begin
                lat = k;
                n_tests++;
                if (a_out_data !== expect_out(w, 4, 1)) begin n_fail++; $display("FAIL mid_new_data got=%h exp=%h", a_out_data, expect_out(w, 4, 1)); end
            end
        end
        n_tests++; if (lat != 4 || early != 0) begin n_fail++; $display("FAIL mid_new_latency got=%0d stale=%0d exp 4/0", lat, early); end
    endtask

    task automatic test_corner();
        logic [DW-1:0] q[$];
        logic [DW-1:0] w, e;
        int acc, outs;
        acc = 0; outs = 0;
        do_reset();
        k_out_ready = 1;
        w = DW'($urandom);
        k_in_valid = 1;
        k_in_data = w;
        #1;
        n_tests++; if (k_in_ready !== 1'b1) begin n_fail++; $display("FAIL corner_accept got=%b exp=1", k_in_ready); end
        @(negedge clk);
        k_in_valid = 0;
        #1;
        n_tests++; if (k_out_valid !== 1'b1 || k_out_data !== w) begin n_fail++; $display("FAIL corner_latency1 valid=%b got=%h exp=%h", k_out_valid, k_out_data, w); end
        w = DW'($urandom);
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            k_in_valid = 1;
            k_in_data  = w;
            #1;
            n_tests++;
            if (k_in_ready !== ((cyc % 2) == 0) || k_out_valid !== ((cyc % 2) == 1)) begin
                n_fail++; $display("FAIL corner_alternate cyc=%0d in_ready=%b out_valid=%b", cyc, k_in_ready, k_out_valid);
            end
            if (k_out_valid === 1'b1) begin
                outs++;
                e = (q.size() > 0) ? q.pop_front() : ~k_out_data;
                if (k_out_data !== e) begin n_fail++; $display("FAIL corner_data got=%h exp=%h", k_out_data, e); end
            end
            if (k_in_ready) begin
                q.push_back(expect_out(w, 1, 0));
                acc++;
                w = DW'($urandom);
            end
        end
        k_in_valid = 0;
        n_tests++; if (acc != 6 || outs != 6) begin n_fail++; $display("FAIL corner_throughput acc=%0d out=%0d exp 6/6", acc, outs); end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] w, e;
        bit pend;
        int n_out;
        pend = 0; n_out = 0; w = '0;
        do_reset();
        for (int cyc = 0; cyc < 440; cyc++) begin
            @(negedge clk);
            if (!pend) begin
                a_in_valid = (cyc < 400) && ($urandom_range(0, 3) != 0);
                w = DW'($urandom);
                a_in_data = w;
            end
            a_out_ready = (cyc >= 400) || ($urandom_range(0, 2) != 0);
            #1;
            n_tests++;
            if (a_occ !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_occ cyc=%0d got=%b exp=%0d", cyc, a_occ, q.size() > 0); end
            if (a_out_valid === 1'b1 && a_out_ready) begin
                n_tests++;
                e = (q.size() > 0) ? q.pop_front() : ~a_out_data;
                if (a_out_data !== e) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, a_out_data, e); end
                n_out++;
            end
            if (a_in_valid && a_in_ready) begin
                q.push_back(expect_out(w, 4, 1));
                pend = 0;
            end else begin
                pend = a_in_valid;
            end
        end
        @(negedge clk);
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_lost remaining=%0d exp=0", q.size()); end
        n_tests++; if (a_cnt !== 16'(n_out)) begin n_fail++; $display("FAIL rand_xfer_cnt got=%0d exp=%0d", a_cnt, n_out); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_corner();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
